// File: rtl/cp0_regfile_ng.sv
// cp0_regfile_ng: MIPS CP0 register file beside the WB stage.
// Holds BadVAddr, Count, Compare, Status, Cause and EPC, with a Count
// prescaler, a Count/Compare timer interrupt and synchronised external
// interrupt lines feeding Cause.IP.
module cp0_regfile_ng #(
    parameter int N_EXT_INT   = 6,   // external interrupt inputs, 1..6
    parameter int COUNT_DIV   = 2,   // clk cycles per Count increment, 1..16
    parameter int SYNC_STAGES = 2    // 0 = no synchroniser, else 2 flops
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 mtc0_we,
    input  logic [7:0]           c0_addr,
    input  logic [31:0]          c0_wdata,
    input  logic                 wb_ex,
    input  logic                 wb_bd,
    input  logic [4:0]           wb_excode,
    input  logic [31:0]          wb_pc,
    input  logic [31:0]          wb_badvaddr,
    input  logic                 eret_flush,
    input  logic [N_EXT_INT-1:0] ext_int_in,
    output logic [31:0]          c0_rdata,
    output logic [31:0]          c0_epc,
    output logic                 has_int,
    output logic                 timer_int
);

    // {rd, sel} addresses of the implemented registers
    localparam logic [7:0] ADDR_BADVADDR = {5'd8,  3'd0};
    localparam logic [7:0] ADDR_COUNT    = {5'd9,  3'd0};
    localparam logic [7:0] ADDR_COMPARE  = {5'd11, 3'd0};
    localparam logic [7:0] ADDR_STATUS   = {5'd12, 3'd0};
    localparam logic [7:0] ADDR_CAUSE    = {5'd13, 3'd0};
    localparam logic [7:0] ADDR_EPC      = {5'd14, 3'd0};

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    // Prescaler width; a 1-bit counter that never leaves 0 when COUNT_DIV=1
    localparam int              PW        = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(COUNT_DIV - 1);

    logic [31:0]          badvaddr_q;
    logic [31:0]          count_q;
    logic [31:0]          compare_q;
    logic [31:0]          epc_q;
    logic [7:0]           im_q;
    logic                 exl_q;
    logic                 ie_q;
    logic                 bd_q;
    logic                 ti_q;
    logic [4:0]           exccode_q;
    logic [1:0]           ip_sw_q;     // Cause.IP[1:0], software interrupts
    logic [5:0]           ip_hw_q;     // Cause.IP[7:2], sampled hardware lines
    logic [PW-1:0]        presc_q;
    logic [N_EXT_INT-1:0] s_ext;
    logic [5:0]           ext_pad;

    // Event arbitration: an exception masks ERET, and either masks MTC0
    logic eret_go;
    logic wr_go;
    logic wr_count;
    logic wr_compare;
    logic wr_status;
    logic wr_cause;
    logic wr_epc;
    logic tick;
    logic ti_set;

    assign eret_go    = eret_flush & ~wb_ex;
    assign wr_go      = mtc0_we & ~wb_ex & ~eret_flush;
    assign wr_count   = wr_go && (c0_addr == ADDR_COUNT);
    assign wr_compare = wr_go && (c0_addr == ADDR_COMPARE);
    assign wr_status  = wr_go && (c0_addr == ADDR_STATUS);
    assign wr_cause   = wr_go && (c0_addr == ADDR_CAUSE);
    assign wr_epc     = wr_go && (c0_addr == ADDR_EPC);

    assign tick   = (presc_q == PRESC_MAX);
    // Timer fires only on a real increment landing on Compare, never on a load
    assign ti_set = tick && !wr_count && ((count_q + 32'd1) == compare_q);

    // Optional two-flop synchroniser on the external interrupt lines
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s_ext = ext_int_in;
        end else begin : g_sync
            logic [N_EXT_INT-1:0] meta_q;
            logic [N_EXT_INT-1:0] sync_q;
            // Two-stage capture of the asynchronous interrupt levels
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    meta_q <= '0;
                    sync_q <= '0;
                end else begin
                    meta_q <= ext_int_in;
                    sync_q <= meta_q;
                end
            end
            assign s_ext = sync_q;
        end
    endgenerate

    // Zero-extend the synchronised lines to the six hardware IP slots
    always_comb begin
        ext_pad = '0;
        for (int i = 0; i < N_EXT_INT; i++) begin
            ext_pad[i] = s_ext[i];
        end
    end

    // Prescaler: counts 0..COUNT_DIV-1, restarted by an MTC0 to Count
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!resetn) begin
            presc_q <= '0;
        end else if (wr_count || tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    // Count/Compare timer and its interrupt flag (a Compare write clears TI and wins)
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            if (wr_count) begin
                count_q <= c0_wdata;
            end else if (tick) begin
                count_q <= count_q + 32'd1;
            end
            if (wr_compare) begin
                compare_q <= c0_wdata;
                ti_q      <= 1'b0;
            end else if (ti_set) begin
                ti_q <= 1'b1;
            end
        end
    end

    // Status: exception sets EXL, ERET clears it, MTC0 writes IM/EXL/IE
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            im_q  <= '0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
        end else if (wb_ex) begin
            exl_q <= 1'b1;
        end else if (eret_go) begin
            exl_q <= 1'b0;
        end else if (wr_status) begin
            im_q  <= c0_wdata[15:8];
            exl_q <= c0_wdata[1];
            ie_q  <= c0_wdata[0];
        end
    end

    // Exception capture into Cause/EPC/BadVAddr, plus MTC0 Cause.IP[1:0] and EPC
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            exccode_q  <= '0;
            bd_q       <= 1'b0;
            epc_q      <= '0;
            badvaddr_q <= '0;
            ip_sw_q    <= '0;
        end else if (wb_ex) begin
            exccode_q <= wb_excode;
            // Nested exceptions keep the original return point
            if (!exl_q) begin
                bd_q  <= wb_bd;
                epc_q <= wb_bd ? (wb_pc - 32'd4) : wb_pc;
            end
            if ((wb_excode == EXC_ADEL) || (wb_excode == EXC_ADES)) begin
                badvaddr_q <= wb_badvaddr;
            end
        end else begin
            if (wr_cause) begin
                ip_sw_q <= c0_wdata[9:8];
            end
            if (wr_epc) begin
                epc_q <= c0_wdata;
            end
        end
    end

    // Hardware interrupt pending bits, resampled every cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ip_hw_q <= '0;
        end else begin
            ip_hw_q <= {ti_q | ext_pad[5], ext_pad[4:0]};
        end
    end

    // MFC0 read mux; unmapped addresses and sel!=0 read as zero
    always_comb begin
        // NOTE: default first so every path assigns c0_rdata and no latch is inferred.
        c0_rdata = '0;
        case (c0_addr)
            ADDR_BADVADDR: c0_rdata = badvaddr_q;
            ADDR_COUNT:    c0_rdata = count_q;
            ADDR_COMPARE:  c0_rdata = compare_q;
            ADDR_STATUS:   c0_rdata = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
            ADDR_CAUSE:    c0_rdata = {bd_q, ti_q, 14'd0, ip_hw_q, ip_sw_q,
                                       1'b0, exccode_q, 2'b00};
            ADDR_EPC:      c0_rdata = epc_q;
            default:       c0_rdata = '0;
        endcase
    end

    assign c0_epc    = epc_q;
    assign timer_int = ti_q;
    assign has_int   = (|({ip_hw_q, ip_sw_q} & im_q)) & ie_q & ~exl_q;

endmodule
